pmips_mem_arbiter: RTL and testbench

//  Shares one single-ported 17-bit memory between the PMIPS instruction-fetch port and the data (MEM-stage) port.

---
 rtl/pmips_mem_pkg.sv | 9 +
 rtl/pmips_mem_timeout.sv | 19 +
 rtl/pmips_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_pmips_mem_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pmips_mem_pkg.sv
// pmips_mem_pkg: shared widths, timer sizing and FSM encoding for the PMIPS memory arbiter.
package pmips_mem_pkg;
  localparam int PM_ADDR_W      = 16;
  localparam int PM_IDATA_W     = 17;
  localparam int PM_DDATA_W     = 16;
  localparam int PM_TIMEOUT_CYC = 255;
  localparam int PM_TMR_W       = 8;
  typedef enum logic [1:0] {S_IDLE, S_DACC, S_IACC} state_e;
endpackage

// File: rtl/pmips_mem_timeout.sv
// pmips_mem_timeout: counts cycles while enabled and flags the cycle in which TIMEOUT_CYC is reached.
module pmips_mem_timeout
  import pmips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = PM_TIMEOUT_CYC
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  logic [PM_TMR_W-1:0] cnt_q, cnt_d;
  assign cnt_d    = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  assign expire_o = en_i & (cnt_q == PM_TMR_W'(TIMEOUT_CYC - 1));
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/pmips_mem_arbiter.sv
// pmips_mem_arbiter: shares one memory between fetch and data ports, stalling the pipeline until both finish.
// Optional PMIPS_FETCH_BUF_EN adds a one-entry fetch buffer that skips repeat fetches of the same address.
module pmips_mem_arbiter
  import pmips_mem_pkg::*;
#(
  parameter int ADDR_W      = PM_ADDR_W,
  parameter int IDATA_W     = PM_IDATA_W,
  parameter int DDATA_W     = PM_DDATA_W,
  parameter int TIMEOUT_CYC = PM_TIMEOUT_CYC
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ireq,
  input  logic [ADDR_W-1:0]  imemaddr,
  output logic [IDATA_W-1:0] imemrdata,
  input  logic               dmemread,
  input  logic               dmemwrite,
  input  logic [ADDR_W-1:0]  dmemaddr,
  input  logic [DDATA_W-1:0] dmemwdata,
  output logic [DDATA_W-1:0] dmemrdata,
  output logic               stall,
  output logic               bus_err,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [IDATA_W-1:0] mem_wdata,
  input  logic [IDATA_W-1:0] mem_rdata,
  input  logic               mem_ack
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [IDATA_W-1:0] mem_wdata_q, mem_wdata_d, imemrdata_q, imemrdata_d, fb_instr;
  logic [DDATA_W-1:0] dmemrdata_q, dmemrdata_d;
  logic mem_we_q, mem_we_d, bus_err_q, bus_err_d, idone_q, idone_d, ddone_q, ddone_d;
  logic dpend, ipend, busy, expire, iset, dset, hit;
  assign dpend = (dmemread | dmemwrite) & ~ddone_q;
  assign ipend = ireq & ~idone_q;
  assign busy  = state_q != S_IDLE;
  assign stall = reset & (dpend | ipend);
  pmips_mem_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clock(clock), .reset(reset), .clr_i(~busy), .en_i(busy), .expire_o(expire)
  );
`ifdef PMIPS_FETCH_BUF_EN
  logic               fb_valid_q;
  logic [ADDR_W-1:0]  fb_addr_q;
  logic [IDATA_W-1:0] fb_instr_q;
  assign hit      = fb_valid_q & (fb_addr_q == imemaddr);
  assign fb_instr = fb_instr_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      fb_valid_q <= 1'b0;
      fb_addr_q  <= '0;
      fb_instr_q <= '0;
    end else if (state_q == S_IACC && mem_ack) begin
      fb_valid_q <= 1'b1;
      fb_addr_q  <= mem_addr_q;
      fb_instr_q <= mem_rdata;
    end else if (expire || (state_q == S_DACC && mem_ack && mem_we_q && mem_addr_q == fb_addr_q))
      fb_valid_q <= 1'b0;
`else
  assign hit      = 1'b0;
  assign fb_instr = '0;
`endif
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    imemrdata_d = imemrdata_q;
    dmemrdata_d = dmemrdata_q;
    bus_err_d   = bus_err_q;
    iset        = 1'b0;
    dset        = 1'b0;
    case (state_q)
      S_IDLE:
        if (dpend) begin
          state_d     = S_DACC;
          mem_addr_d  = dmemaddr;
          mem_we_d    = dmemwrite;
          mem_wdata_d = {{(IDATA_W-DDATA_W){1'b0}}, dmemwdata};
        end else if (ipend & hit) begin
          iset        = 1'b1;
          imemrdata_d = fb_instr;
        end else if (ipend) begin
          state_d     = S_IACC;
          mem_addr_d  = imemaddr;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
        end
      S_DACC:
        if (mem_ack | expire) begin
          state_d   = S_IDLE;
          dset      = 1'b1;
          mem_we_d  = 1'b0;
          bus_err_d = bus_err_q | ~mem_ack;
          if (!mem_we_q) dmemrdata_d = mem_ack ? mem_rdata[DDATA_W-1:0] : '0;
        end
      S_IACC:
        if (mem_ack | expire) begin
          state_d     = S_IDLE;
          iset        = 1'b1;
          bus_err_d   = bus_err_q | ~mem_ack;
          imemrdata_d = mem_ack ? mem_rdata : '0;
        end
      default: state_d = S_IDLE;
    endcase
    // completion flags survive only while the pipeline is still frozen
    idone_d = stall & (idone_q | iset);
    ddone_d = stall & (ddone_q | dset);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      imemrdata_q <= '0;
      dmemrdata_q <= '0;
      bus_err_q   <= 1'b0;
      idone_q     <= 1'b0;
      ddone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      imemrdata_q <= imemrdata_d;
      dmemrdata_q <= dmemrdata_d;
      bus_err_q   <= bus_err_d;
      idone_q     <= idone_d;
      ddone_q     <= ddone_d;
    end
  assign mem_req   = busy;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign imemrdata = imemrdata_q;
  assign dmemrdata = dmemrdata_q;
  assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_pmips_mem_arbiter.sv
// tb_pmips_mem_arbiter: scoreboard bench; expected memory transactions are queued and checked by the memory model.
module tb_pmips_mem_arbiter;
  logic        clock = 1'b0, reset = 1'b0;
  logic        ireq = 1'b0, dmemread = 1'b0, dmemwrite = 1'b0, mem_ack = 1'b0;
  logic [15:0] imemaddr = '0, dmemaddr = '0, dmemwdata = '0, dmemrdata, mem_addr;
  logic [16:0] imemrdata, mem_wdata, mem_rdata = '0;
  logic        stall, bus_err, mem_req, mem_we;
  int          n_chk = 0, n_pass = 0, n_txn = 0, rcnt = 0, last_len = 0, ack_dly = 1, cyc;
  logic [63:0] exp_q[$];
  logic [16:0] mem[int];

  pmips_mem_arbiter dut (
    .clock(clock), .reset(reset), .ireq(ireq), .imemaddr(imemaddr), .imemrdata(imemrdata),
    .dmemread(dmemread), .dmemwrite(dmemwrite), .dmemaddr(dmemaddr), .dmemwdata(dmemwdata),
    .dmemrdata(dmemrdata), .stall(stall), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] txn(input logic we, input logic [15:0] a, input logic [16:0] wd);
    return {30'd0, we, a, wd};
  endfunction

  // memory model: acks in the ack_dly-th request cycle (0 = never), checks each new request
  always @(negedge clock) begin
    if (mem_req) begin
      rcnt++;
      last_len = rcnt;
      if (rcnt == 1) begin
        n_txn++;
        if (exp_q.size() == 0) chk("txn_unexpected", txn(mem_we, mem_addr, mem_wdata), 64'hFFFF_FFFF);
        else chk("txn", txn(mem_we, mem_addr, mem_wdata), exp_q.pop_front());
      end
      if (ack_dly != 0 && rcnt == ack_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 17'h0;
        if (mem_we) mem[int'(mem_addr)] = mem_wdata;
      end else mem_ack = 1'b0;
    end else begin
      rcnt    = 0;
      mem_ack = 1'b0;
    end
  end

  // drive at a negedge, count stalled cycles, then drop the request for one free cycle
  task automatic access(input logic i, input logic [15:0] ia, input logic rd, input logic wr,
                        input logic [15:0] da, input logic [15:0] dw, output int n);
    ireq = i; imemaddr = ia; dmemread = rd; dmemwrite = wr; dmemaddr = da; dmemwdata = dw;
    n = 0;
    #1;
    while (stall && n < 400) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= 400) chk("stall_bound", 64'(n), 64'd0);
    ireq = 1'b0; dmemread = 1'b0; dmemwrite = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int t0;
    mem[32'h10]  = 17'h1ABCD;
    mem[32'h20]  = 17'h15555;
    mem[32'h100] = 17'h01234;
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_bus_err", 64'(bus_err), 64'd0);
    chk("rst_imemrdata", 64'(imemrdata), 64'd0);
    chk("rst_dmemrdata", 64'(dmemrdata), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    ack_dly = 2; t0 = n_txn;
    exp_q.push_back(txn(1'b0, 16'h0010, 17'h0));
    access(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, cyc);
    chk("fetch_stall_cyc", 64'(cyc), 64'd3);
    chk("fetch_data", 64'(imemrdata), 64'h1ABCD);
    chk("fetch_txn_cnt", 64'(n_txn - t0), 64'd1);
    chk("fetch_req_len", 64'(last_len), 64'd2);

    ack_dly = 1; t0 = n_txn;
    exp_q.push_back(txn(1'b0, 16'h0100, 17'h0));
    exp_q.push_back(txn(1'b0, 16'h0020, 17'h0));
    access(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0100, 16'h0, cyc);
    chk("both_stall_cyc", 64'(cyc), 64'd4);
    chk("both_dmemrdata", 64'(dmemrdata), 64'h1234);
    chk("both_imemrdata", 64'(imemrdata), 64'h15555);
    chk("both_txn_cnt", 64'(n_txn - t0), 64'd2);

    ack_dly = 3;
    exp_q.push_back(txn(1'b1, 16'h0200, 17'h0BEEF));
    access(1'b0, 16'h0, 1'b0, 1'b1, 16'h0200, 16'hBEEF, cyc);
    chk("wr_stall_cyc", 64'(cyc), 64'd4);
    chk("wr_dmemrdata_kept", 64'(dmemrdata), 64'h1234);
    exp_q.push_back(txn(1'b0, 16'h0200, 17'h0));
    access(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0, cyc);
    chk("rd_back", 64'(dmemrdata), 64'hBEEF);

    ack_dly = 0;
    exp_q.push_back(txn(1'b0, 16'h0040, 17'h0));
    access(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, cyc);
    chk("to_stall_cyc", 64'(cyc), 64'd256);
    chk("to_req_len", 64'(last_len), 64'd255);
    chk("to_bus_err", 64'(bus_err), 64'd1);
    chk("to_imemrdata", 64'(imemrdata), 64'd0);
    chk("to_mem_req", 64'(mem_req), 64'd0);

    ack_dly = 1;
    exp_q.push_back(txn(1'b0, 16'h0010, 17'h0));
    access(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, cyc);
    chk("post_to_data", 64'(imemrdata), 64'h1ABCD);
    chk("bus_err_sticky", 64'(bus_err), 64'd1);

    ack_dly = 0;
    exp_q.push_back(txn(1'b0, 16'h0050, 17'h0));
    ireq = 1'b1; imemaddr = 16'h0050;
    repeat (3) @(negedge clock);
    #1;
    chk("mid_mem_req", 64'(mem_req), 64'd1);
    reset = 1'b0;
    #1;
    chk("arst_mem_req", 64'(mem_req), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_imemrdata", 64'(imemrdata), 64'd0);
    chk("arst_bus_err", 64'(bus_err), 64'd0);
    chk("arst_mem_addr", 64'(mem_addr), 64'd0);
    ireq = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("idle_mem_req", 64'(mem_req), 64'd0);
    chk("idle_stall", 64'(stall), 64'd0);
    ack_dly = 2;
    exp_q.push_back(txn(1'b0, 16'h0010, 17'h0));
    access(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, cyc);
    chk("after_rst_cyc", 64'(cyc), 64'd3);
    chk("after_rst_data", 64'(imemrdata), 64'h1ABCD);

`ifdef PMIPS_FETCH_BUF_EN
    mem[32'h30] = 17'h13030;
    ack_dly = 1; t0 = n_txn;
    exp_q.push_back(txn(1'b0, 16'h0030, 17'h0));
    access(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0, 16'h0, cyc);
    access(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0, 16'h0, cyc);
    chk("fb_hit_cyc", 64'(cyc), 64'd1);
    chk("fb_hit_data", 64'(imemrdata), 64'h13030);
    chk("fb_hit_txn", 64'(n_txn - t0), 64'd1);
    exp_q.push_back(txn(1'b1, 16'h0030, 17'h00777));
    access(1'b0, 16'h0, 1'b0, 1'b1, 16'h0030, 16'h0777, cyc);
    exp_q.push_back(txn(1'b0, 16'h0030, 17'h0));
    access(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0, 16'h0, cyc);
    chk("fb_inval_txn", 64'(n_txn - t0), 64'd3);
    chk("fb_inval_data", 64'(imemrdata), 64'h00777);
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
